// File: rtl/sdram_bist.sv
// sdram_bist: memory built-in self-test engine for the SDRAM controller host port.
// For every enabled data pattern it writes the whole word-address range, then
// reads it back and compares each word, counting miscompares.
//
// Optional feature macro: SDRAM_BIST_ERR_LOG_EN
//   defined   -> first miscompare of a run is captured in first_err_addr/exp/got
//   undefined -> no capture registers; those three ports are tied to 0
//
// Host handshake: cs is the request (valid) and h_compl is the completion.
// cs is held with a stable h_addr/h_wr_en/h_wdata from the first cycle of an
// access until the cycle h_compl=1; in that cycle cs and h_bytesel already drop
// combinationally, so the controller never sees a second request for the
// same access. h_rdata is sampled only in the cycle h_compl=1.
//
// dbg_state exposes the FSM state encoding for external checkers.

module sdram_bist #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop_on_err,
  input  logic [3:0]                pat_mask,
  input  logic [ADDR_WIDTH-1:0]     start_addr,
  input  logic [ADDR_WIDTH-1:0]     end_addr,
  output logic                      cs,
  output logic [ADDR_WIDTH-1:0]     h_addr,
  output logic                      h_wr_en,
  output logic [DATA_WIDTH/8-1:0]   h_bytesel,
  output logic [DATA_WIDTH-1:0]     h_wdata,
  input  logic [DATA_WIDTH-1:0]     h_rdata,
  input  logic                      h_compl,
  input  logic                      h_config_done,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [1:0]                cur_pattern,
  output logic [ADDR_WIDTH-1:0]     first_err_addr,
  output logic [DATA_WIDTH-1:0]     first_err_exp,
  output logic [DATA_WIDTH-1:0]     first_err_got,
  output logic [2:0]                dbg_state
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Modulo width for the walking-one shift: wide enough for the address and
  // for DATA_WIDTH itself.
  localparam int MW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CFG = 3'd1,
    S_WRITE    = 3'd2,
    S_WR_INC   = 3'd3,
    S_READ     = 3'd4,
    S_RD_INC   = 3'd5,
    S_NEXT_PAT = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [1:0]               pat_q;
  logic [3:0]               mask_q;
  logic [ADDR_WIDTH-1:0]    start_q;
  logic [ADDR_WIDTH-1:0]    end_q;
  logic                     stop_q;
  logic [ERR_CNT_WIDTH-1:0] err_q;
  logic                     tmo_flag_q;
  logic [TW-1:0]            tmo_cnt_q;

  logic                     start_ok;
  logic                     acc_state;
  logic                     tmo_hit;
  logic                     miscmp;
  logic                     last_addr;
  logic [DATA_WIDTH-1:0]    exp_data;
  logic [2:0]               first_pat;
  logic [2:0]               next_pat;

  // Data pattern for a given word address and pattern index.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [1:0] p);
    logic [DATA_WIDTH-1:0] av;
    logic [DATA_WIDTH-1:0] chk;
    logic [MW-1:0]         sh;
    logic [DATA_WIDTH-1:0] r;
    av  = DATA_WIDTH'(a);
    sh  = MW'(a) % MW'(DATA_WIDTH);
    chk = '0;
    // Byte checkerboard: 8'haa where byte index bits 0 and 1 are equal.
    for (int i = 0; i < BW; i++) begin
      chk[8*i +: 8] = ((i % 4 == 0) || (i % 4 == 3)) ? 8'haa : 8'h55;
    end
    case (p)
      2'd0:    r = av + DATA_WIDTH'(1);
      2'd1:    r = av[0] ? ~chk : chk;
      2'd2:    r = ~(av + DATA_WIDTH'(1));
      default: r = DATA_WIDTH'(1) << sh;
    endcase
    return r;
  endfunction

  // Lowest enabled pattern with index >= lo; bit 2 of the result flags "found".
  function automatic logic [2:0] find_pat(input logic [3:0] m, input logic [2:0] lo);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= lo)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign start_ok  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign acc_state = (state_q == S_WRITE) || (state_q == S_READ);
  assign exp_data  = pattern(addr_q, pat_q);
  assign tmo_hit   = acc_state && !h_compl && (tmo_cnt_q == TMO_LAST);
  assign miscmp    = (state_q == S_READ) && h_compl && (h_rdata != exp_data);
  // Covers end_addr < start_addr as well: only start_addr is tested then.
  assign last_addr = (addr_q >= end_q);
  assign first_pat = find_pat(mask_q, 3'd0);
  assign next_pat  = find_pat(mask_q, {1'b0, pat_q} + 3'd1);

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (pat_mask == 4'd0) ? S_DONE : S_WAIT_CFG;
      end
      S_WAIT_CFG: begin
        if (h_config_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (h_compl)      state_d = S_WR_INC;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_READ: begin
        if (h_compl)      state_d = (miscmp && stop_q) ? S_DONE : S_RD_INC;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_WR_INC:   state_d = last_addr ? S_READ : S_WRITE;
      S_RD_INC:   state_d = last_addr ? S_NEXT_PAT : S_READ;
      S_NEXT_PAT: state_d = next_pat[2] ? S_WRITE : S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State register plus run configuration, address, pattern and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pat_q      <= '0;
      mask_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      stop_q     <= 1'b0;
      err_q      <= '0;
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      // Per-access timer: runs only while an access stays pending, so it
      // restarts from zero on every entry to WRITE/READ.
      if (acc_state && (state_d == state_q)) tmo_cnt_q <= tmo_cnt_q + TW'(1);
      else                                   tmo_cnt_q <= '0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mask_q     <= pat_mask;
            start_q    <= start_addr;
            end_q      <= end_addr;
            stop_q     <= stop_on_err;
            err_q      <= '0;
            tmo_flag_q <= 1'b0;
          end
        end
        S_WAIT_CFG: begin
          if (h_config_done) begin
            pat_q  <= first_pat[1:0];
            addr_q <= start_q;
          end
        end
        S_WRITE: begin
          if (tmo_hit) tmo_flag_q <= 1'b1;
        end
        S_READ: begin
          if (tmo_hit) tmo_flag_q <= 1'b1;
          if (miscmp && (err_q != '1)) err_q <= err_q + 1'b1;
        end
        S_WR_INC, S_RD_INC: begin
          addr_q <= last_addr ? start_q : addr_q + 1'b1;
        end
        S_NEXT_PAT: begin
          if (next_pat[2]) pat_q <= next_pat[1:0];
        end
        default: ;
      endcase
    end
  end

`ifdef SDRAM_BIST_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] fe_addr_q;
  logic [DATA_WIDTH-1:0] fe_exp_q;
  logic [DATA_WIDTH-1:0] fe_got_q;

  // Capture the first miscompare of the run; cleared by start.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
    end else if (miscmp && (err_q == '0)) begin
      fe_addr_q <= addr_q;
      fe_exp_q  <= exp_data;
      fe_got_q  <= h_rdata;
    end
  end

  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;
`else
  assign first_err_addr = '0;
  assign first_err_exp  = '0;
  assign first_err_got  = '0;
`endif

  // Host port and status outputs; rst forces them low in the reset cycle so an
  // access in flight is dropped immediately.
  assign cs          = !rst && acc_state && !h_compl;
  assign h_bytesel   = {BW{cs}};
  assign h_wr_en     = !rst && (state_q == S_WRITE);
  assign h_wdata     = (!rst && (state_q == S_WRITE)) ? exp_data : '0;
  assign h_addr      = addr_q;
  assign busy        = !rst && (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = !rst && (state_q == S_DONE);
  assign pass        = done && (err_q == '0) && !tmo_flag_q;
  assign timeout     = tmo_flag_q;
  assign err_count   = err_q;
  assign cur_pattern = pat_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: scoreboard bench for sdram_bist. A behavioural SDRAM model
// answers host accesses with random latency (optionally corrupting bit 0 at
// one address, or never completing). Each run's expected access sequence is
// built from the pattern rules and queued; a monitor pops and compares every
// access the DUT issues. End-of-run status is checked against the same model.

module tb_sdram_bist;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int EW = 16;
  localparam int TO = 16;
  localparam int W  = 1 + AW + DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop_on_err;
  logic [3:0]    pat_mask;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          cs;
  logic [AW-1:0] h_addr;
  logic          h_wr_en;
  logic [DW/8-1:0] h_bytesel;
  logic [DW-1:0] h_wdata;
  logic [DW-1:0] h_rdata;
  logic          h_compl;
  logic          h_config_done;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [EW-1:0] err_count;
  logic [1:0]    cur_pattern;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_exp;
  logic [DW-1:0] first_err_got;
  logic [2:0]    dbg_state;

  sdram_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_err(stop_on_err),
    .pat_mask(pat_mask), .start_addr(start_addr), .end_addr(end_addr),
    .cs(cs), .h_addr(h_addr), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel),
    .h_wdata(h_wdata), .h_rdata(h_rdata), .h_compl(h_compl),
    .h_config_done(h_config_done), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .cur_pattern(cur_pattern),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // ---------------- SDRAM model ----------------
  int            mode = 0;      // 0 ideal, 1 bit-0 fault at fault_addr on read, 2 never completes
  int            lat_max = 2;
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit            m_busy = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_d;

  initial begin
    h_compl = 1'b0;
    h_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        h_compl = 1'b0; h_rdata = '0; m_busy = 1'b0;
      end else if (h_compl) begin
        h_compl = 1'b0; h_rdata = '0;
      end else if (cs && mode != 2) begin
        if (!m_busy) begin
          m_busy = 1'b1;
          m_cnt  = $urandom_range(0, lat_max);
        end
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          if (h_wr_en) mem[h_addr] = h_wdata;
          else begin
            m_d = mem.exists(h_addr) ? mem[h_addr] : '0;
            if (mode == 1 && h_addr == fault_addr) m_d = m_d ^ 32'h1;
            h_rdata = m_d;
          end
          h_compl = 1'b1;
        end else begin
          m_cnt--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic         prev_act = 1'b0;
  logic         act;
  logic [W-1:0] mon_obs;
  logic [W-1:0] mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) prev_act = 1'b0;
      else begin
        act = cs | h_compl;
        if (act && !prev_act) begin
          mon_obs = {h_wr_en, h_addr, h_wdata};
          if (exp_q.size() == 0) check("unexpected_access", mon_obs, '0);
          else begin
            mon_exp = exp_q.pop_front();
            check("access", mon_obs, mon_exp);
          end
          if (cs) check("bytesel", h_bytesel, 4'hf);
        end
        prev_act = act;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_pat(input int p, input logic [AW-1:0] a);
    logic [DW-1:0] av;
    av = {2'b00, a};
    case (p)
      0:       return av + 32'd1;
      1:       return a[0] ? 32'h55aaaa55 : 32'haa5555aa;
      2:       return ~(av + 32'd1);
      default: return 32'h1 << (a % 32);
    endcase
  endfunction

  // Queue the expected access sequence and final status for one run.
  task automatic plan_run(input logic [3:0] mask, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input bit stop, input bit flt, input logic [AW-1:0] fa,
                          output int exp_err, output int exp_pat, output logic [AW-1:0] fea,
                          output logic [DW-1:0] fee, output logic [DW-1:0] feg);
    int n;
    bit stopped;
    logic [AW-1:0] a;
    exp_err = 0; exp_pat = -1; fea = '0; fee = '0; feg = '0; stopped = 1'b0;
    n = (ea < sa) ? 1 : int'(ea - sa) + 1;
    for (int p = 0; p < 4; p++) begin
      if (mask[p] && !stopped) begin
        exp_pat = p;
        for (int k = 0; k < n; k++) begin
          a = sa + AW'(k);
          exp_q.push_back({1'b1, a, ref_pat(p, a)});
        end
        for (int k = 0; k < n; k++) begin
          if (!stopped) begin
            a = sa + AW'(k);
            exp_q.push_back({1'b0, a, 32'h0});
            if (flt && a == fa) begin
              if (exp_err == 0) begin
                fea = a; fee = ref_pat(p, a); feg = ref_pat(p, a) ^ 32'h1;
              end
              exp_err++;
              if (stop) stopped = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_run(input string tag, input logic [3:0] mask, input logic [AW-1:0] sa,
                        input logic [AW-1:0] ea, input bit stop, input bit flt,
                        input logic [AW-1:0] fa, input int cfg_delay, input bit poke,
                        input int budget);
    int exp_err, exp_pat, n, cs_seen;
    logic [AW-1:0] fea;
    logic [DW-1:0] fee, feg;
    mode = flt ? 1 : 0;
    fault_addr = fa;
    plan_run(mask, sa, ea, stop, flt, fa, exp_err, exp_pat, fea, fee, feg);
    if (cfg_delay > 0) h_config_done = 1'b0;
    @(negedge clk);
    start = 1'b1; pat_mask = mask; start_addr = sa; end_addr = ea; stop_on_err = stop;
    @(negedge clk);
    start = 1'b0;
    pat_mask = 4'($urandom); start_addr = AW'($urandom); end_addr = AW'($urandom);
    stop_on_err = 1'($urandom);
    if (cfg_delay > 0) begin
      cs_seen = 0;
      for (int i = 0; i < cfg_delay; i++) begin
        if (cs) cs_seen++;
        @(negedge clk);
      end
      check({tag, "_cs_before_cfg"}, cs_seen, 0);
      h_config_done = 1'b1;
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; pat_mask = 4'hf; start_addr = 7; end_addr = 9;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    if (!done) apply_reset();
    else begin
      check({tag, "_pass"}, pass, (exp_err == 0));
      check({tag, "_err_count"}, err_count, exp_err);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      if (exp_pat >= 0) check({tag, "_cur_pattern"}, cur_pattern, exp_pat);
`ifdef SDRAM_BIST_ERR_LOG_EN
      check({tag, "_first_err"}, {first_err_addr, first_err_exp, first_err_got}, {fea, fee, feg});
`else
      check({tag, "_first_err"}, {first_err_addr, first_err_exp, first_err_got}, '0);
`endif
      exp_q.delete();
    end
  endtask

  task automatic timeout_run();
    int k, n;
    mode = 2;
    exp_q.push_back({1'b1, 30'd3, ref_pat(0, 30'd3)});
    @(negedge clk);
    start = 1'b1; pat_mask = 4'b0001; start_addr = 3; end_addr = 8; stop_on_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!cs && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cs_rise", cs, 1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", n, TO);
    check("tmo_flag", timeout, 1);
    check("tmo_pass", pass, 0);
    check("tmo_cs_low", cs, 0);
    check("tmo_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    mode = 0;
  endtask

  task automatic reset_mid_read();
    int k, e0, e1;
    logic [AW-1:0] fea;
    logic [DW-1:0] fee, feg;
    mode = 0;
    plan_run(4'b0001, 0, 31, 1'b0, 1'b0, 0, e0, e1, fea, fee, feg);
    @(negedge clk);
    start = 1'b1; pat_mask = 4'b0001; start_addr = 0; end_addr = 31; stop_on_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(cs && !h_wr_en) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_reached_read", cs && !h_wr_en, 1);
    #2 rst = 1'b1;
    #1 check("rst_cs_same_cycle", cs, 0);
    exp_q.delete();
    @(posedge clk);
    #2 check("rst_outputs_zero",
             {cs, h_addr, h_wr_en, h_bytesel, h_wdata, busy, done, pass, timeout, err_count,
              cur_pattern, first_err_addr, first_err_exp, first_err_got, dbg_state}, '0);
    #1 rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] sa, ea, fa;
    int len;
    rst = 1'b1; start = 1'b0; stop_on_err = 1'b0; pat_mask = '0;
    start_addr = '0; end_addr = '0; h_config_done = 1'b1;
    apply_reset();
    @(negedge clk);
    check("reset_outputs_zero",
          {cs, h_addr, h_wr_en, h_bytesel, h_wdata, busy, done, pass, timeout, err_count,
           cur_pattern, first_err_addr, first_err_exp, first_err_got, dbg_state}, '0);

    do_run("sweep",     4'b0011, 0, 30'h3ff, 1'b0, 1'b0, 0, 0, 1'b1, 40000);
    do_run("fault",     4'b0001, 0, 30'h3f, 1'b0, 1'b1, 30'h10, 0, 1'b0, 5000);
    do_run("fault_stop",4'b0001, 0, 30'h3f, 1'b1, 1'b1, 30'h10, 0, 1'b0, 5000);
    do_run("cfg_wait",  4'b0100, 0, 30'hf, 1'b0, 1'b0, 0, 500, 1'b0, 5000);
    do_run("mask_zero", 4'b0000, 5, 30'h9, 1'b0, 1'b0, 0, 0, 1'b0, 10);
    timeout_run();

    for (int it = 0; it < 8; it++) begin
      sa  = AW'($urandom_range(10, 2000));
      len = $urandom_range(0, 40);
      ea  = ($urandom_range(0, 4) == 0) ? sa - AW'($urandom_range(1, 5)) : sa + AW'(len);
      fa  = (ea < sa) ? sa : sa + AW'($urandom_range(0, len));
      do_run("random", 4'($urandom_range(1, 15)), sa, ea, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), fa, 0, 1'b0, 5000);
    end

    reset_mid_read();
    do_run("one_word", 4'b1111, 100, 50, 1'b0, 1'b0, 0, 0, 1'b0, 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
